// File: rtl/mpeg_start_code_scanner_pkg.sv
// mpeg_start_code_scanner_pkg: shared constants and state encoding for the start-code scanner
package mpeg_start_code_scanner_pkg;
    localparam logic [23:0] START_CODE_PREFIX = 24'h000001;
    localparam logic [7:0] SC_PICTURE    = 8'h00;
    localparam logic [7:0] SC_SEQ_HEADER = 8'hB3;
    localparam logic [7:0] SC_EXTENSION  = 8'hB5;
    localparam logic [7:0] SC_GOP        = 8'hB8;
    localparam logic [7:0] SC_SEQ_END    = 8'hB7;
    typedef enum logic [1:0] {IDLE, SCAN, FOUND} state_t;
endpackage

// File: rtl/mpeg_start_code_scanner_if.sv
// mpeg_start_code_scanner_if: upstream byte-window and parser handshake signals of the scanner
interface mpeg_start_code_scanner_if #(parameter int SKIP_COUNT_WIDTH = 16);
    logic [31:0]                 Bitstream_Data_I;
    logic                        Buffer_Empty_I;
    logic                        Shift_8_En_O;
    logic                        Scan_Start_I;
    logic                        Shift_8_Req_I;
    logic                        Start_Code_Valid_O;
    logic [7:0]                  Start_Code_O;
    logic                        Start_Code_Ack_I;
    logic [SKIP_COUNT_WIDTH-1:0] Skip_Count_O;
    logic                        Busy_O;
    logic [31:0]                 Bitstream_Data_O;
    modport slave (
        input  Bitstream_Data_I, Buffer_Empty_I, Scan_Start_I, Shift_8_Req_I, Start_Code_Ack_I,
        output Shift_8_En_O, Start_Code_Valid_O, Start_Code_O, Skip_Count_O, Busy_O, Bitstream_Data_O
    );
    modport master (
        output Bitstream_Data_I, Buffer_Empty_I, Scan_Start_I, Shift_8_Req_I, Start_Code_Ack_I,
        input  Shift_8_En_O, Start_Code_Valid_O, Start_Code_O, Skip_Count_O, Busy_O, Bitstream_Data_O
    );
endinterface

// File: rtl/mpeg_start_code_scanner.sv
// mpeg_start_code_scanner: byte-aligned search for 00 00 01 xx in the upstream window, with parser pass-through
module mpeg_start_code_scanner
    import mpeg_start_code_scanner_pkg::*;
#(
    parameter int SKIP_COUNT_WIDTH = 16
) (
    input logic clock,
    input logic resetn,
    input logic Restart_I,
    mpeg_start_code_scanner_if.slave bus
);
    state_t state, state_nx;
    logic [2:0] fill_cnt;
    logic min_shift;
    logic [SKIP_COUNT_WIDTH-1:0] skip_cnt;
    logic [7:0] start_code;
    logic match, shift_en;
    // window is only trusted once four shifts have primed it since reset
    assign match = (bus.Bitstream_Data_I[31:8] == START_CODE_PREFIX) && (fill_cnt == 3'd4) && !min_shift;
    assign bus.Shift_8_En_O = shift_en;
    assign bus.Start_Code_Valid_O = (state == FOUND);
    assign bus.Start_Code_O = start_code;
    assign bus.Skip_Count_O = skip_cnt;
    assign bus.Busy_O = (state != IDLE);
    assign bus.Bitstream_Data_O = bus.Bitstream_Data_I;
    always_comb begin
        state_nx = state;
        shift_en = 1'b0;
        unique case (state)
            IDLE: begin
                shift_en = bus.Shift_8_Req_I & ~bus.Buffer_Empty_I;
                state_nx = bus.Scan_Start_I ? SCAN : IDLE;
            end
            SCAN: begin
                shift_en = ~match & ~bus.Buffer_Empty_I;
                state_nx = (match & ~bus.Buffer_Empty_I) ? FOUND : SCAN;
            end
            FOUND: state_nx = bus.Start_Code_Ack_I ? IDLE : FOUND;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            fill_cnt <= 3'd0;
            min_shift <= 1'b0;
            skip_cnt <= '0;
            start_code <= 8'h00;
        end else if (Restart_I) begin
            state <= IDLE;
            fill_cnt <= 3'd0;
            min_shift <= 1'b0;
            skip_cnt <= '0;
            start_code <= 8'h00;
        end else begin
            state <= state_nx;
            if (shift_en && fill_cnt != 3'd4) fill_cnt <= fill_cnt + 3'd1;
            if (state == IDLE && bus.Scan_Start_I) begin
                skip_cnt <= '0;
                min_shift <= 1'b1;
            end
            if (state == SCAN && shift_en) begin
                min_shift <= 1'b0;
                skip_cnt <= &skip_cnt ? skip_cnt : skip_cnt + SKIP_COUNT_WIDTH'(1);
            end
            if (state == SCAN && state_nx == FOUND) start_code <= bus.Bitstream_Data_I[7:0];
        end
    end
endmodule

// File: tb/tb_mpeg_start_code_scanner.sv
// tb_mpeg_start_code_scanner: byte-stream upstream emulation plus stream-level reference search model
module tb_mpeg_start_code_scanner;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic restart = 1'b0;
    logic scan_start = 1'b0;
    logic req = 1'b0;
    logic ack = 1'b0;
    logic stall = 1'b0;
    logic [31:0] win;
    int shift_cnt;
    logic [7:0] all_bytes[$];
    int checks = 0;
    int errors = 0;

    typedef struct {logic req; logic empty; logic exp_en;} pt_vec_t;
    pt_vec_t pt[6];

    always #5 clock = ~clock;

    mpeg_start_code_scanner_if #(.SKIP_COUNT_WIDTH(16)) sif ();
    assign sif.Bitstream_Data_I = win;
    assign sif.Buffer_Empty_I = stall;
    assign sif.Scan_Start_I = scan_start;
    assign sif.Shift_8_Req_I = req;
    assign sif.Start_Code_Ack_I = ack;

    mpeg_start_code_scanner #(.SKIP_COUNT_WIDTH(16)) dut (
        .clock(clock), .resetn(resetn), .Restart_I(restart), .bus(sif.slave)
    );

    function automatic logic [7:0] byte_at(input int i);
        return (i < all_bytes.size()) ? all_bytes[i] : 8'h55;
    endfunction

    // upstream stage: window holds the last four bytes shifted out of the stream
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            win <= 32'h0;
            shift_cnt <= 0;
        end else if (restart) begin
            win <= 32'h0;
            shift_cnt <= 0;
        end else if (sif.Shift_8_En_O) begin
            win <= {win[23:0], byte_at(shift_cnt)};
            shift_cnt <= shift_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic append(input logic [7:0] b[]);
        while (all_bytes.size() < shift_cnt) all_bytes.push_back(8'h55);
        foreach (b[i]) all_bytes.push_back(b[i]);
    endtask

    // first k>=1 more bytes after which the last four consumed bytes read 00 00 01 xx
    function automatic void model(input int n, output int k_exp, output logic [7:0] code_exp);
        k_exp = -1;
        code_exp = 8'h00;
        for (int k = 1; k < 1000; k++) begin
            int p;
            p = n + k;
            if (p >= 4 && byte_at(p-4) == 8'h00 && byte_at(p-3) == 8'h00 && byte_at(p-2) == 8'h01) begin
                k_exp = k;
                code_exp = byte_at(p-1);
                return;
            end
        end
    endfunction

    task automatic do_scan(input string tag, input int fixed_skip, input int fixed_code,
                           input int stall_at, input int stall_len, input bit rnd);
        int n, k_exp;
        logic [7:0] c_exp;
        bit seen;
        scan_start = 1'b1;
        @(negedge clock);
        scan_start = 1'b0;
        n = shift_cnt;
        model(n, k_exp, c_exp);
        seen = 1'b0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            stall = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            if (sif.Start_Code_Valid_O) seen = 1'b1;
            else begin
                if (stall) chk({tag, " stall_shift"}, sif.Shift_8_En_O, 1'b0);
                @(negedge clock);
            end
        end
        stall = 1'b0;
        chk({tag, " found"}, seen, 1'b1);
        chk({tag, " code"}, sif.Start_Code_O, c_exp);
        chk({tag, " skip"}, sif.Skip_Count_O, k_exp);
        if (fixed_skip >= 0) chk({tag, " skip_exact"}, sif.Skip_Count_O, fixed_skip);
        if (fixed_code >= 0) chk({tag, " code_exact"}, sif.Start_Code_O, fixed_code);
        chk({tag, " busy"}, sif.Busy_O, 1'b1);
        req = 1'b1;
        #1;
        chk({tag, " found_no_shift"}, sif.Shift_8_En_O, 1'b0);
        @(negedge clock);
        req = 1'b0;
        #1;
        chk({tag, " valid_held"}, sif.Start_Code_Valid_O, 1'b1);
    endtask

    task automatic ack_found(input bit with_start);
        logic [7:0] held;
        held = sif.Start_Code_O;
        ack = 1'b1;
        scan_start = with_start;
        @(negedge clock);
        ack = 1'b0;
        scan_start = 1'b0;
        #1;
        chk("ack valid_drop", sif.Start_Code_Valid_O, 1'b0);
        chk("ack busy_drop", sif.Busy_O, 1'b0);
        chk("ack code_hold", sif.Start_Code_O, held);
        if (with_start) begin
            @(negedge clock);
            #1;
            chk("ack_start ignored", sif.Busy_O, 1'b0);
        end
    endtask

    initial begin
        pt[0] = '{1'b0, 1'b0, 1'b0};
        pt[1] = '{1'b1, 1'b0, 1'b1};
        pt[2] = '{1'b1, 1'b1, 1'b0};
        pt[3] = '{1'b0, 1'b1, 1'b0};
        pt[4] = '{1'b1, 1'b0, 1'b1};
        pt[5] = '{1'b0, 1'b0, 1'b0};
        req = 1'b1;
        #1;
        chk("rst valid", sif.Start_Code_Valid_O, 1'b0);
        chk("rst code", sif.Start_Code_O, 8'h00);
        chk("rst skip", sif.Skip_Count_O, 16'h0);
        chk("rst busy", sif.Busy_O, 1'b0);
        req = 1'b0;
        all_bytes = '{8'h00, 8'h00, 8'h01, 8'hB3};
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        do_scan("prime", 4, 8'hB3, 0, 0, 1'b0);
        chk("prime shifts", shift_cnt, 4);
        ack_found(1'b0);
        append('{8'h00, 8'h00, 8'h01, 8'h00});
        do_scan("rescan", 4, 8'h00, 0, 0, 1'b0);
        ack_found(1'b1);

        append('{8'hA1, 8'hA2});
        foreach (pt[i]) begin
            req = pt[i].req;
            stall = pt[i].empty;
            #1;
            chk($sformatf("passthru[%0d] shift", i), sif.Shift_8_En_O, pt[i].exp_en);
            chk($sformatf("passthru[%0d] data", i), sif.Bitstream_Data_O, win);
            @(negedge clock);
        end
        req = 1'b0;
        stall = 1'b0;

        append('{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01, 8'hB8});
        do_scan("garbage", 7, 8'hB8, 0, 0, 1'b0);
        ack_found(1'b0);
        append('{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h01, 8'hB8});
        do_scan("stall", 7, 8'hB8, 2, 5, 1'b0);
        ack_found(1'b0);

        append('{8'h12, 8'h34, 8'h56, 8'h78});
        scan_start = 1'b1;
        @(negedge clock);
        scan_start = 1'b0;
        repeat (3) @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        #1;
        chk("restart valid", sif.Start_Code_Valid_O, 1'b0);
        chk("restart skip", sif.Skip_Count_O, 16'h0);
        chk("restart busy", sif.Busy_O, 1'b0);
        all_bytes.delete();
        all_bytes = '{8'h00, 8'h00, 8'h01, 8'hB5};
        do_scan("reprime", 4, 8'hB5, 0, 0, 1'b0);
        chk("reprime shifts", shift_cnt, 4);
        ack_found(1'b0);

        for (int it = 0; it < 25; it++) begin
            logic [7:0] g[];
            int len;
            len = $urandom_range(0, 10);
            g = new[len + 4];
            for (int j = 0; j < len; j++) begin
                int r;
                r = $urandom_range(0, 3);
                g[j] = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : 8'($urandom);
            end
            g[len] = 8'h00;
            g[len+1] = 8'h00;
            g[len+2] = 8'h01;
            g[len+3] = 8'($urandom);
            append(g);
            do_scan($sformatf("rand%0d", it), -1, -1, 0, 0, 1'b1);
            ack_found(it[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
